imem_responder: RTL

Instruction-memory responder for the barrel-threaded RV32I core: the memory end of the fetch stage's instruction-address interface. It accepts one tagged fetch request per cycle, returns the instruction word one cycle later with the thread ID echoed, and owns a byte-stream program loader that fills the memory while fetch is held off.

---
 rtl/imem_responder.sv | 95 +++++++++
 1 files changed

// File: rtl/imem_responder.sv
// imem_responder: one-cycle tagged instruction fetch port plus byte-stream program loader
//   clk/rst (async, active low); fetch: req_valid/req_addr/req_tid -> resp_valid/resp_instr/resp_tid/resp_err
//   loader: ld_start/ld_base/ld_valid/ld_byte/ld_last -> ld_ready/busy/ld_done/ld_words
module imem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int IMEM_SIZE = 1024,
  parameter int NUM_THREADS = 4,
  localparam int BITS_THREADS = $clog2(NUM_THREADS),
  localparam int IW = $clog2(IMEM_SIZE),
  localparam int LW = IW + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [BITS_THREADS-1:0]  req_tid,
  output logic                     resp_valid,
  output logic [DATA_WIDTH-1:0]    resp_instr,
  output logic [BITS_THREADS-1:0]  resp_tid,
  output logic                     resp_err,
  input  logic                     ld_start,
  input  logic [ADDRESS_WIDTH-1:0] ld_base,
  input  logic                     ld_valid,
  input  logic [7:0]               ld_byte,
  input  logic                     ld_last,
  output logic                     ld_ready,
  output logic                     busy,
  output logic                     ld_done,
  output logic [LW-1:0]            ld_words
);
  localparam logic [DATA_WIDTH-1:0] NOP = 32'h00000013;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state;
  logic [IW-1:0] ptr;
  logic [1:0] bcnt;
  logic [23:0] asm_q;
  logic [DATA_WIDTH-1:0] mem [IMEM_SIZE];
  logic acc, wr_en, served, misal;
  logic [4:0] sh;
  logic [DATA_WIDTH-1:0] wr_word;
  logic unused;
  assign busy = state != IDLE;
  assign ld_ready = state == LOAD;
  assign ld_done = state == DONE;
  assign acc = state == LOAD && ld_valid;
  assign wr_en = acc && (bcnt == 2'd3 || ld_last);
  assign sh = {bcnt, 3'b000};
  // Keep bytes already assembled below the current slot, drop the new byte in, leave upper bytes zero
  // so a short final word is zero-filled for free.
  assign wr_word = ({8'h00, asm_q} & ~({DATA_WIDTH{1'b1}} << sh)) | ({24'h000000, ld_byte} << sh);
  assign served = state == IDLE && req_valid;
  assign misal = |req_addr[1:0];
  assign unused = ^{req_addr[ADDRESS_WIDTH-1:IW+2], ld_base[ADDRESS_WIDTH-1:IW+2], ld_base[1:0], wr_word[31:24]};
  always_ff @(posedge clk)
    if (wr_en) mem[ptr] <= wr_word;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr <= '0;
      bcnt <= '0;
      asm_q <= '0;
      ld_words <= '0;
      resp_valid <= 1'b0;
      resp_instr <= '0;
      resp_tid <= '0;
      resp_err <= 1'b0;
    end else begin
      resp_valid <= served;
      if (served) begin
        resp_tid <= req_tid;
        resp_err <= misal;
        resp_instr <= misal ? NOP : mem[req_addr[IW+1:2]];
      end
      case (state)
        IDLE: if (ld_start) begin
          state <= LOAD;
          ptr <= ld_base[IW+1:2];
          bcnt <= '0;
          ld_words <= '0;
        end
        LOAD: if (acc) begin
          asm_q <= wr_word[23:0];
          bcnt <= ld_last ? 2'd0 : bcnt + 2'd1;
          if (wr_en) begin
            ptr <= ptr + IW'(1);
            ld_words <= ld_words == LW'(IMEM_SIZE) ? ld_words : ld_words + LW'(1);
          end
          if (ld_last) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
